// File: rtl/pcie_cfg_pkg.sv
// Shared definitions for the config-request sequencer:
//   - request type codes (4-bit descriptor field)
//   - response status codes returned to the host
//   - FSM state encoding
//   - descriptor field bit positions on the 128-bit RQ beat
//   - small helpers for request-type selection and counter sizing
package pcie_cfg_pkg;

  localparam logic [3:0] REQ_T0_RD = 4'b1000;
  localparam logic [3:0] REQ_T0_WR = 4'b1001;
  localparam logic [3:0] REQ_T1_RD = 4'b1010;
  localparam logic [3:0] REQ_T1_WR = 4'b1011;

  typedef enum logic [2:0] {
    STS_SC      = 3'd0,
    STS_UR      = 3'd1,
    STS_CRS     = 3'd2,
    STS_CA      = 3'd4,
    STS_TIMEOUT = 3'd7
  } cfg_status_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_DATA    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_BACKOFF = 3'd4,
    ST_RESP    = 3'd5
  } cfg_state_e;

  localparam int DESC_REG_LSB     = 2;
  localparam int DESC_REG_W       = 10;
  localparam int DESC_DWCNT_LSB   = 64;
  localparam int DESC_DWCNT_W     = 11;
  localparam int DESC_REQTYPE_LSB = 75;
  localparam int DESC_REQID_LSB   = 80;
  localparam int DESC_TAG_LSB     = 96;
  localparam int DESC_BDF_LSB     = 104;

  function automatic logic [3:0] req_type(input logic write, input logic type1);
    case ({type1, write})
      2'b00:   return REQ_T0_RD;
      2'b01:   return REQ_T0_WR;
      2'b10:   return REQ_T1_RD;
      default: return REQ_T1_WR;
    endcase
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pcie_cfg_req_ctrl_if.sv
// Bus bundle between the host/enumeration logic, the config decoder and
// the config-request sequencer.
//   cmd_*         : one-at-a-time config command from the host
//   rsp_*         : one-cycle response pulse with status and read data
//   s_axis_rq_*   : 128-bit RQ AXI-Stream toward the core
//   config_mode   : tells the decoder a config transaction is outstanding
//   cpl_*         : completion pulses from the decoder
// Modports: master = host/decoder/core side, slave = sequencer.
interface pcie_cfg_req_ctrl_if #(
  parameter int C_DATA_WIDTH = 128,
  parameter int TUSER_WIDTH  = 60
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic                      cmd_write;
  logic                      cmd_type1;
  logic [15:0]               cmd_bdf;
  logic [9:0]                cmd_reg;
  logic [3:0]                cmd_be;
  logic [31:0]               cmd_wdata;

  logic                      rsp_valid;
  logic [2:0]                rsp_status;
  logic [31:0]               rsp_rdata;

  logic [C_DATA_WIDTH-1:0]   s_axis_rq_tdata;
  logic [C_DATA_WIDTH/32-1:0] s_axis_rq_tkeep;
  logic                      s_axis_rq_tlast;
  logic                      s_axis_rq_tvalid;
  logic                      s_axis_rq_tready;
  logic [TUSER_WIDTH-1:0]    s_axis_rq_tuser;

  logic                      config_mode;

  logic                      cpl_sc;
  logic                      cpl_ur;
  logic                      cpl_crs;
  logic                      cpl_ca;
  logic                      cpl_mismatch;
  logic [31:0]               cpl_data;

  modport master (
    output cmd_valid, cmd_write, cmd_type1, cmd_bdf, cmd_reg, cmd_be, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_status, rsp_rdata,
    input  s_axis_rq_tdata, s_axis_rq_tkeep, s_axis_rq_tlast, s_axis_rq_tvalid,
    input  s_axis_rq_tuser,
    output s_axis_rq_tready,
    input  config_mode,
    output cpl_sc, cpl_ur, cpl_crs, cpl_ca, cpl_mismatch, cpl_data
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_type1, cmd_bdf, cmd_reg, cmd_be, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_status, rsp_rdata,
    output s_axis_rq_tdata, s_axis_rq_tkeep, s_axis_rq_tlast, s_axis_rq_tvalid,
    output s_axis_rq_tuser,
    input  s_axis_rq_tready,
    output config_mode,
    input  cpl_sc, cpl_ur, cpl_crs, cpl_ca, cpl_mismatch, cpl_data
  );
endinterface

// File: rtl/pcie_cfg_rq_desc_builder.sv
// Combinational formatting of the RQ beats for one config request.
// Inputs : latched command fields and the current tag.
// Outputs: desc_beat (descriptor beat), data_beat (write payload beat).
module pcie_cfg_rq_desc_builder
  import pcie_cfg_pkg::*;
#(
  parameter logic [15:0] REQUESTER_ID = 16'h10EE,
  parameter int          C_DATA_WIDTH = 128
) (
  input  logic                    cmd_write,
  input  logic                    cmd_type1,
  input  logic [15:0]             cmd_bdf,
  input  logic [9:0]              cmd_reg,
  input  logic [31:0]             cmd_wdata,
  input  logic [7:0]              tag,
  output logic [C_DATA_WIDTH-1:0] desc_beat,
  output logic [C_DATA_WIDTH-1:0] data_beat
);

  always_comb begin
    desc_beat = '0;
    desc_beat[DESC_REG_LSB     +: DESC_REG_W]   = cmd_reg;
    desc_beat[DESC_DWCNT_LSB   +: DESC_DWCNT_W] = 11'd1;
    desc_beat[DESC_REQTYPE_LSB +: 4]            = req_type(cmd_write, cmd_type1);
    desc_beat[DESC_REQID_LSB   +: 16]           = REQUESTER_ID;
    desc_beat[DESC_TAG_LSB     +: 8]            = tag;
    desc_beat[DESC_BDF_LSB     +: 16]           = cmd_bdf;

    data_beat        = '0;
    data_beat[31:0]  = cmd_wdata;
  end

endmodule

// File: rtl/pcie_cfg_req_ctrl.sv
// Config-request sequencer for the Root Port. Accepts one config read/write
// from the host, emits a Type0/Type1 request on the RQ stream, waits for the
// decoder's completion pulse (or timeout) and returns status/read data.
// Ports: user_clk, reset (async, active high), bus (pcie_cfg_req_ctrl_if.slave).
// Build option: PCIE_CFG_CRS_RETRY_EN enables CRS back-off and re-issue;
// without it a CRS completion is reported to the host immediately.
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | ready for a command, config_mode low
// HDR     | presenting descriptor beat
// DATA    | presenting write payload beat
// WAIT    | waiting for a completion pulse or timeout
// BACKOFF | CRS back-off before re-issue (retry build only)
// RESP    | one-cycle rsp_valid to the host
module pcie_cfg_req_ctrl
  import pcie_cfg_pkg::*;
#(
  parameter logic [15:0] REQUESTER_ID        = 16'h10EE,
  parameter int          C_DATA_WIDTH        = 128,
  parameter int          KEEP_WIDTH          = C_DATA_WIDTH/32,
  parameter int          AXI4_RQ_TUSER_WIDTH = 60,
  parameter int          TIMEOUT_CYCLES      = 50000,
  parameter int          MAX_CRS_RETRY       = 8,
  parameter int          CRS_BACKOFF_CYCLES  = 1000
) (
  input logic               user_clk,
  input logic               reset,
  pcie_cfg_req_ctrl_if.slave bus
);

  // one counter serves both the completion timeout and the CRS back-off
  localparam int CNT_W = $clog2(max_int(TIMEOUT_CYCLES, CRS_BACKOFF_CYCLES) + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  cfg_state_e  state_q, state_d;
  cfg_status_e sts_q, sts_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ld_rsp;

  logic        cmd_write_q, cmd_type1_q;
  logic [15:0] cmd_bdf_q;
  logic [9:0]  cmd_reg_q;
  logic [3:0]  cmd_be_q;
  logic [31:0] cmd_wdata_q;
  logic [7:0]  tag_q;
  logic [CNT_W-1:0] cnt_q;
  logic        emit_done;

  logic [C_DATA_WIDTH-1:0]        desc_beat, data_beat, tdata;
  logic [KEEP_WIDTH-1:0]          tkeep;
  logic [AXI4_RQ_TUSER_WIDTH-1:0] tuser;
  logic                           tvalid, tlast;

`ifdef PCIE_CFG_CRS_RETRY_EN
  localparam int RETRY_W = $clog2(MAX_CRS_RETRY + 1);
  localparam logic [CNT_W-1:0]   BO_LAST   = CNT_W'(CRS_BACKOFF_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_CRS_RETRY);
  logic [RETRY_W-1:0] retry_q;
`endif

  pcie_cfg_rq_desc_builder #(
    .REQUESTER_ID (REQUESTER_ID),
    .C_DATA_WIDTH (C_DATA_WIDTH)
  ) u_desc (
    .cmd_write (cmd_write_q),
    .cmd_type1 (cmd_type1_q),
    .cmd_bdf   (cmd_bdf_q),
    .cmd_reg   (cmd_reg_q),
    .cmd_wdata (cmd_wdata_q),
    .tag       (tag_q),
    .desc_beat (desc_beat),
    .data_beat (data_beat)
  );

  always_ff @(posedge user_clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ld_rsp  = 1'b0;
    sts_d   = STS_SC;
    rdata_d = '0;
    unique case (state_q)
      ST_IDLE: if (bus.cmd_valid) state_d = ST_HDR;
      ST_HDR:  if (bus.s_axis_rq_tready) state_d = cmd_write_q ? ST_DATA : ST_WAIT;
      ST_DATA: if (bus.s_axis_rq_tready) state_d = ST_WAIT;
      ST_WAIT: begin
        // completion pulses are checked before the timeout so one landing
        // on the last wait cycle still wins
        if (bus.cpl_sc) begin
          state_d = ST_RESP; ld_rsp = 1'b1; sts_d = STS_SC;
          rdata_d = cmd_write_q ? 32'd0 : bus.cpl_data;
        end else if (bus.cpl_ur) begin
          state_d = ST_RESP; ld_rsp = 1'b1; sts_d = STS_UR;
        end else if (bus.cpl_ca) begin
          state_d = ST_RESP; ld_rsp = 1'b1; sts_d = STS_CA;
        end else if (bus.cpl_crs) begin
`ifdef PCIE_CFG_CRS_RETRY_EN
          if (retry_q < RETRY_MAX) begin
            state_d = ST_BACKOFF;
          end else begin
            state_d = ST_RESP; ld_rsp = 1'b1; sts_d = STS_CRS;
          end
`else
          state_d = ST_RESP; ld_rsp = 1'b1; sts_d = STS_CRS;
`endif
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_RESP; ld_rsp = 1'b1; sts_d = STS_TIMEOUT;
        end
      end
`ifdef PCIE_CFG_CRS_RETRY_EN
      ST_BACKOFF: if (cnt_q == BO_LAST) state_d = ST_HDR;
`endif
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // last beat of a request accepted by the core
  assign emit_done = bus.s_axis_rq_tready &&
                     ((state_q == ST_HDR && !cmd_write_q) || state_q == ST_DATA);

  always_ff @(posedge user_clk or posedge reset) begin
    if (reset) begin
      cmd_write_q <= 1'b0;
      cmd_type1_q <= 1'b0;
      cmd_bdf_q   <= '0;
      cmd_reg_q   <= '0;
      cmd_be_q    <= '0;
      cmd_wdata_q <= '0;
      tag_q       <= '0;
      cnt_q       <= '0;
      sts_q       <= STS_SC;
      rdata_q     <= '0;
    end else begin
      if (state_q == ST_IDLE && bus.cmd_valid) begin
        cmd_write_q <= bus.cmd_write;
        cmd_type1_q <= bus.cmd_type1;
        cmd_bdf_q   <= bus.cmd_bdf;
        cmd_reg_q   <= bus.cmd_reg;
        cmd_be_q    <= bus.cmd_be;
        cmd_wdata_q <= bus.cmd_wdata;
      end
      if (emit_done) tag_q <= tag_q + 8'd1;
      // restart on every state change so WAIT/BACKOFF count from 0
      cnt_q <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
      if (ld_rsp) begin
        sts_q   <= sts_d;
        rdata_q <= rdata_d;
      end
    end
  end

`ifdef PCIE_CFG_CRS_RETRY_EN
  always_ff @(posedge user_clk or posedge reset) begin
    if (reset)                                             retry_q <= '0;
    else if (state_q == ST_IDLE)                           retry_q <= '0;
    else if (state_q == ST_BACKOFF && state_d == ST_HDR)   retry_q <= retry_q + 1'b1;
  end
`endif

  always_comb begin
    tvalid = 1'b0;
    tdata  = '0;
    tkeep  = '0;
    tlast  = 1'b0;
    tuser  = '0;
    unique case (state_q)
      ST_HDR: begin
        tvalid     = 1'b1;
        tdata      = desc_beat;
        tkeep      = '1;
        tlast      = !cmd_write_q;
        tuser[3:0] = cmd_be_q;
      end
      ST_DATA: begin
        tvalid     = 1'b1;
        tdata      = data_beat;
        tkeep      = KEEP_WIDTH'(1);
        tlast      = 1'b1;
        tuser[3:0] = cmd_be_q;
      end
      default: ;
    endcase
  end

  assign bus.s_axis_rq_tvalid = tvalid;
  assign bus.s_axis_rq_tdata  = tdata;
  assign bus.s_axis_rq_tkeep  = tkeep;
  assign bus.s_axis_rq_tlast  = tlast;
  assign bus.s_axis_rq_tuser  = tuser;
  assign bus.cmd_ready        = (state_q == ST_IDLE);
  assign bus.config_mode      = (state_q != ST_IDLE);
  assign bus.rsp_valid        = (state_q == ST_RESP);
  assign bus.rsp_status       = sts_q;
  assign bus.rsp_rdata        = rdata_q;

endmodule
